// File: rtl/lock_pkg.sv
// Shared types and helpers for the combination-lock controller.
// Provides state encodings, a clog2 helper and a one-hot key index helper.
package lock_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_OPEN,
    S_FAIL,
    S_LOCKOUT,
    S_PROG
  } lock_state_t;

  function automatic int lock_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Lowest set bit; callers treat multi-hot separately.
  function automatic int key_index(input logic [31:0] k);
    int idx;
    idx = 0;
    for (int i = 31; i >= 0; i--)
      if (k[i]) idx = i;
    return idx;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by entry-timeout, open and lockout.
// Ports: clk, reset, load, load_val[W], zero (count is 0).
module lock_timer
  import lock_pkg::*;
#(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/code_lock_fsm.sv
// Combination-lock controller: digit entry, code compare, unlock/error/lockout.
// Ports: clk, reset, key_pulse, clear_pulse, [prog_pulse with CODE_PROG_EN],
// unlocked, error, locked_out, entry_cnt, fail_cnt. Macro: CODE_PROG_EN.
module code_lock_fsm
  import lock_pkg::*;
#(
  parameter int N_KEYS   = 4,
  parameter int KEY_W    = lock_clog2(N_KEYS),
  parameter int CODE_LEN = 4,
  parameter logic [CODE_LEN*KEY_W-1:0] CODE =
    {2'd2, 2'd0, 2'd3, 2'd1},
  parameter int OPEN_CYCLES    = 16,
  parameter int ENTRY_TIMEOUT  = 32,
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_pulse,
  input  logic              clear_pulse,
`ifdef CODE_PROG_EN
  input  logic              prog_pulse,
`endif
  output logic              unlocked,
  output logic              error,
  output logic              locked_out,
  output logic [lock_clog2(CODE_LEN+1)-1:0] entry_cnt,
  output logic [lock_clog2(MAX_FAIL+1)-1:0] fail_cnt
);

  localparam int CW = CODE_LEN * KEY_W;
  localparam int EW = lock_clog2(CODE_LEN + 1);
  localparam int FW = lock_clog2(MAX_FAIL + 1);
  localparam int TW = lock_clog2(
    ENTRY_TIMEOUT + OPEN_CYCLES + LOCKOUT_CYCLES + 1);
  localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAIL - 1);
  localparam logic [EW-1:0] LAST_DIG  = EW'(CODE_LEN - 1);

  lock_state_t     state;
  logic            match;
  logic            key_ev;
  logic            key_one;
  logic [KEY_W-1:0] key_idx;
  logic [KEY_W-1:0] cur_digit;
  logic            digit_ok;
  logic            last;
  logic            tmr_load;
  logic [TW-1:0]   tmr_val;
  logic            tmr_zero;
  logic [CW-1:0]   code_w;

`ifdef CODE_PROG_EN
  logic [CW-1:0] code_q;
  logic [CW-1:0] prog_buf;
  logic [CW-1:0] prog_next;
  assign code_w = code_q;
`else
  assign code_w = CODE;
`endif

  assign key_ev   = |key_pulse;
  assign key_one  = $onehot(key_pulse);
  assign key_idx  = KEY_W'(key_index(32'(key_pulse)));
  assign digit_ok = key_one && (key_idx == cur_digit);
  assign last     = (entry_cnt == LAST_DIG);

  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < CODE_LEN; i++)
      if (entry_cnt == EW'(i))
        cur_digit = code_w[i*KEY_W +: KEY_W];
  end

`ifdef CODE_PROG_EN
  always_comb begin
    prog_next = prog_buf;
    for (int i = 0; i < CODE_LEN; i++)
      if (entry_cnt == EW'(i))
        prog_next[i*KEY_W +: KEY_W] = key_idx;
  end
`endif

  // Timer decode mirrors the state transitions below. Open and
  // lockout load N-1 so their outputs last exactly N cycles.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TW'(ENTRY_TIMEOUT);
    case (state)
      S_IDLE: tmr_load = key_ev;
      S_ENTRY:
        if (!clear_pulse && key_ev) begin
          tmr_load = 1'b1;
          if (last) tmr_val = TW'(OPEN_CYCLES - 1);
        end
      S_FAIL: begin
        tmr_load = 1'b1;
        tmr_val  = TW'(LOCKOUT_CYCLES - 1);
      end
`ifdef CODE_PROG_EN
      S_OPEN: tmr_load = prog_pulse;
      S_PROG: tmr_load = key_ev && !clear_pulse;
`endif
      default: ;
    endcase
  end

  lock_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      match      <= 1'b0;
      entry_cnt  <= '0;
      fail_cnt   <= '0;
      unlocked   <= 1'b0;
      error      <= 1'b0;
      locked_out <= 1'b0;
`ifdef CODE_PROG_EN
      code_q     <= CODE;
      prog_buf   <= CODE;
`endif
    end else begin
      error <= 1'b0;
      case (state)
        S_IDLE:
          if (key_ev) begin
            match     <= digit_ok;
            entry_cnt <= EW'(1);
            state     <= S_ENTRY;
          end
        S_ENTRY:
          if (clear_pulse) begin
            entry_cnt <= '0;
            state     <= S_IDLE;
          end else if (key_ev) begin
            match     <= match & digit_ok;
            entry_cnt <= entry_cnt + 1'b1;
            if (last) begin
              if (match && digit_ok) begin
                state    <= S_OPEN;
                unlocked <= 1'b1;
                fail_cnt <= '0;
              end else begin
                state <= S_FAIL;
                error <= 1'b1;
              end
            end
          end else if (tmr_zero) begin
            entry_cnt <= '0;
            state     <= S_IDLE;
          end
        S_OPEN:
`ifdef CODE_PROG_EN
          if (prog_pulse) begin
            state     <= S_PROG;
            unlocked  <= 1'b0;
            entry_cnt <= '0;
            prog_buf  <= code_q;
          end else
`endif
          if (tmr_zero) begin
            state     <= S_IDLE;
            unlocked  <= 1'b0;
            entry_cnt <= '0;
          end
        S_FAIL: begin
          entry_cnt <= '0;
          match     <= 1'b0;
          if (fail_cnt >= FAIL_LAST) begin
            state      <= S_LOCKOUT;
            locked_out <= 1'b1;
          end else begin
            state    <= S_IDLE;
            fail_cnt <= fail_cnt + 1'b1;
          end
        end
        S_LOCKOUT:
          if (tmr_zero) begin
            state      <= S_IDLE;
            locked_out <= 1'b0;
            fail_cnt   <= '0;
          end
`ifdef CODE_PROG_EN
        S_PROG:
          if (clear_pulse || (key_ev && !key_one) ||
              (!key_ev && tmr_zero)) begin
            state     <= S_IDLE;
            entry_cnt <= '0;
          end else if (key_ev) begin
            prog_buf  <= prog_next;
            entry_cnt <= entry_cnt + 1'b1;
            if (last) begin
              code_q    <= prog_next;
              state     <= S_IDLE;
              entry_cnt <= '0;
            end
          end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
